// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the load/store unit.
//   lsu_state_t    : LSU control states
//   F3_*           : RV32 load/store funct3 width/sign encodings
//   MEM_DATA_WIDTH : data memory word width (must be 32)
//   MEM_ADDR_WIDTH : data memory word-index width
package mem_lsu_pkg;

  localparam int unsigned MEM_DATA_WIDTH = 32;
  localparam int unsigned MEM_ADDR_WIDTH = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RMW_WRITE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: core-side request/response and memory-side bus of the LSU.
//   slave  : the LSU (accepts requests, drives the memory bus)
//   master : the environment (core issuing requests + data memory)
//   req_*  : request handshake and fields (byte address, store data)
//   resp_* : single-cycle completion pulse, load data, error flag
//   mem_*  : word index, write data, write strobe, registered read data
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [2:0]                req_funct3;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;
  logic                      resp_valid;
  logic [31:0]               resp_rdata;
  logic                      resp_err;
  logic [31:0]               mem_addr;
  logic [MEM_DATA_WIDTH-1:0] mem_wdata;
  logic                      mem_rw;
  logic [31:0]               mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_rw
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_rw
  );

endinterface

// File: rtl/mem_lsu_lane_align.sv
// lsu_lane_align: combinational lane handling for the LSU.
//   funct3     : RV32 width/sign code of the access
//   lane       : byte offset within the word (addr[1:0])
//   rdata      : word read from memory
//   wdata      : right-aligned store data
//   load_data  : selected byte/half/word, sign- or zero-extended
//   store_data : rdata with the addressed byte/half replaced (whole wdata for word)
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(rdata >> {lane, 3'b000});
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'b0, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'b0, half_v};
      default: load_data = rdata;
    endcase

    store_data = rdata;
    case (funct3[1:0])
      2'b00: begin
        case (lane)
          2'd0:    store_data[7:0]   = wdata[7:0];
          2'd1:    store_data[15:8]  = wdata[7:0];
          2'd2:    store_data[23:16] = wdata[7:0];
          default: store_data[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) store_data[31:16] = wdata[15:0];
        else         store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: RV32 load/store unit in front of a word-addressed data memory
// (1-cycle registered read, synchronous write). One request at a time;
// SB/SH are done as read-modify-write.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_lsu_if.slave (request/response + memory bus)
// Parameters:
//   BASE_ADDR : byte address of memory word 0
//   MEM_WORDS : number of memory words; accesses outside the window error
// Build option:
//   MEM_LSU_ALIGN_CHECK_EN : misaligned half/word accesses return an error.
//   When undefined, the address is aligned down and the access proceeds.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 2**MEM_ADDR_WIDTH
) (
  input logic      clk,
  input logic      rst,
  mem_lsu_if.slave bus
);

  if (MEM_DATA_WIDTH != 32) begin : g_width_check
    $error("mem_lsu: MEM_DATA_WIDTH must be 32");
  end

  lsu_state_t  state, state_nxt;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [31:0] addr_al;
  logic [32:0] offset;
  logic        range_err;
  logic        funct3_err;
  logic        align_err;
  logic        req_err;
  logic        accept;
  logic        req_is_sw;
  logic [31:0] load_data;
  logic [31:0] store_data;

  // Aligned-down address; only differs from req_addr when misaligned,
  // which is an error anyway if the alignment check is enabled.
  always_comb begin
    addr_al = bus.req_addr;
    if (bus.req_funct3[1:0] == 2'b01)      addr_al[0]   = 1'b0;
    else if (bus.req_funct3[1:0] == 2'b10) addr_al[1:0] = 2'b00;
  end

  // 33-bit subtraction: the borrow flags addresses below BASE_ADDR.
  assign offset    = {1'b0, addr_al} - {1'b0, BASE_ADDR};
  assign range_err = offset[32] || ({32'b0, offset[31:0]} >= (64'(MEM_WORDS) << 2));

  assign funct3_err = bus.req_we ? (bus.req_funct3 > 3'b010)
                                 : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));

`ifdef MEM_LSU_ALIGN_CHECK_EN
  assign align_err = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  assign req_err   = range_err || funct3_err || align_err;
  assign accept    = bus.req_valid && (state == IDLE);
  assign req_is_sw = bus.req_we && (bus.req_funct3[1:0] == 2'b10);

  lsu_lane_align u_align (
    .funct3     (r_funct3),
    .lane       (r_lane),
    .rdata      (bus.mem_rdata),
    .wdata      (r_wdata),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.mem_rw     = 1'b0;
    bus.mem_wdata  = mem_wdata_q;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;

    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (r_we && (r_funct3[1:0] == 2'b10)) begin
          bus.mem_rw = 1'b1;
          state_nxt  = RESP;
        end else if (r_we) begin
          state_nxt  = RMW_WRITE;
        end else begin
          state_nxt  = RESP;
        end
      end
      RMW_WRITE: begin
        // mem_rdata holds the word read during ACCESS; merge and write back.
        bus.mem_rw    = 1'b1;
        bus.mem_wdata = store_data;
        state_nxt     = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = r_err;
        if (!r_err && !r_we) bus.resp_rdata = load_data;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Reset aborts the operation: no write and no completion pulse.
    if (rst) begin
      bus.mem_rw     = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_err   = 1'b0;
      bus.resp_rdata = '0;
    end
  end

  // mem_wdata_q keeps the last driven write data so the output holds
  // between accesses; it is loaded on SW accept and after each RMW write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_lane      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (accept) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_lane   <= addr_al[1:0];
        r_wdata  <= bus.req_wdata;
        r_err    <= req_err;
        if (!req_err) begin
          mem_addr_q <= {2'b00, offset[31:2]};
          if (req_is_sw) mem_wdata_q <= bus.req_wdata;
        end
      end
      if (state == RMW_WRITE) mem_wdata_q <= store_data;
    end
  end

  assign bus.mem_addr = mem_addr_q;

endmodule
